// File: rtl/sha256_block_driver.sv
// sha256_block_driver: sequencing controller and sole bus master for the
// memory-mapped SHA-256 core. Loads 16-word blocks, issues INIT/NEXT, polls
// STATUS, then streams the 8-word digest after the last block of a message.
// Optional feature: define SHA_DRV_WATCHDOG_EN to bound the WAIT state to
// WDOG_CYCLES cycles and flag a sticky err on expiry.
module sha256_block_driver #(
    parameter int unsigned WDOG_CYCLES = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_first,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        err,
    output logic        sha_cs,
    output logic        sha_we,
    output logic [7:0]  sha_address,
    output logic [31:0] sha_write_data,
    input  logic [31:0] sha_read_data
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DIG_W  = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 8'h08;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 8'h09;
    localparam logic [ADDR_W-1:0] ADDR_BLOCK  = 8'h10;
    localparam logic [ADDR_W-1:0] ADDR_DIGEST = 8'h20;

    localparam logic [DATA_W-1:0] CTRL_INIT = 32'h0000_0001;
    localparam logic [DATA_W-1:0] CTRL_NEXT = 32'h0000_0002;

    localparam logic [IDX_W-1:0] LAST_WORD = 4'd15;
    localparam logic [DIG_W-1:0] LAST_DIG  = 3'd7;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CMD    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DIGEST = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [DIG_W-1:0]   dig_q;
    logic               first_q;
    logic               last_q;

    logic               load_accept_c;
    logic               dig_accept_c;
    logic               core_ready_c;

    assign load_accept_c = in_valid && in_ready;
    assign dig_accept_c  = out_valid && out_ready;
    assign core_ready_c  = sha_read_data[0];

`ifdef SHA_DRV_WATCHDOG_EN
    localparam int unsigned WDOG_W = 7;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0]  wdog_q;
    logic               err_q;
    logic               wdog_expire_c;

    assign wdog_expire_c = (state_q == ST_WAIT) && !core_ready_c && (wdog_q == WDOG_LAST);

    // WAIT-cycle counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ST_WAIT) begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end else begin
                wdog_q <= '0;
            end
            if (wdog_expire_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q && reset_n;
`else
    logic [6:0] unused_wdog_cycles;
    assign unused_wdog_cycles = 7'(WDOG_CYCLES);
    assign err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (load_accept_c && (idx_q == LAST_WORD)) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_ready_c) begin
                    state_d = last_q ? ST_DIGEST : ST_LOAD;
                end
`ifdef SHA_DRV_WATCHDOG_EN
                else if (wdog_expire_c) begin
                    state_d = ST_LOAD;
                end
`endif
            end
            ST_DIGEST: begin
                if (dig_accept_c && (dig_q == LAST_DIG)) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Word/digest indices and per-block command flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q   <= '0;
            dig_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (load_accept_c) begin
                idx_q <= idx_q + IDX_W'(1);
                if (idx_q == '0) begin
                    first_q <= in_first;
                    last_q  <= in_last;
                end
            end
            if (dig_accept_c) begin
                dig_q <= dig_q + DIG_W'(1);
            end
        end
    end

    // Bus and stream outputs decoded from state; all forced low while in reset
    always_comb begin
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        busy           = 1'b0;
        sha_cs         = 1'b0;
        sha_we         = 1'b0;
        sha_address    = '0;
        sha_write_data = '0;
        if (reset_n) begin
            case (state_q)
                ST_LOAD: begin
                    in_ready = 1'b1;
                    busy     = (idx_q != '0);
                    if (in_valid) begin
                        sha_cs         = 1'b1;
                        sha_we         = 1'b1;
                        sha_address    = ADDR_BLOCK + ADDR_W'(idx_q);
                        sha_write_data = in_data;
                    end
                end
                ST_CMD: begin
                    busy           = 1'b1;
                    sha_cs         = 1'b1;
                    sha_we         = 1'b1;
                    sha_address    = ADDR_CTRL;
                    sha_write_data = first_q ? CTRL_INIT : CTRL_NEXT;
                end
                ST_WAIT: begin
                    busy        = 1'b1;
                    sha_cs      = 1'b1;
                    sha_address = ADDR_STATUS;
                end
                ST_DIGEST: begin
                    busy        = 1'b1;
                    sha_cs      = 1'b1;
                    sha_address = ADDR_DIGEST + ADDR_W'(dig_q);
                    out_valid   = 1'b1;
                    out_data    = sha_read_data;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_driver.sv
// Bench for sha256_block_driver with a behavioural SHA-256 core stub.
// Build with SHA_DRV_WATCHDOG_EN defined to also exercise the watchdog.
module tb_sha256_block_driver;

    localparam int unsigned WDOG = 100;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [31:0] ABC_DIG [8] = '{
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [31:0] TWO_DIG [8] = '{
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
    };

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        err;
    logic        sha_cs;
    logic        sha_we;
    logic [7:0]  sha_address;
    logic [31:0] sha_write_data;
    logic [31:0] sha_read_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ov_count = 0;

    logic [31:0] words [16];
    logic [31:0] dig [8];
    logic [41:0] cmd_seen;
    int t_w0, t_w15, t_ov, held, hold_bad;

    sha256_block_driver #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err),
        .sha_cs(sha_cs), .sha_we(sha_we), .sha_address(sha_address),
        .sha_write_data(sha_write_data), .sha_read_data(sha_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (out_valid) ov_count <= ov_count + 1;

    // ---------------- behavioural SHA-256 core stub ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    logic [31:0]  blk [16];
    logic [255:0] h_q;
    int           core_cnt;
    logic         stub_stall = 1'b0;

    function automatic logic [511:0] pack_blk();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[511 - 32*i -: 32] = blk[i];
        return m;
    endfunction

    // Core registers: block write, INIT/NEXT command, 65-cycle busy window
    always @(posedge clk) begin
        if (!reset_n) begin
            core_cnt <= 0;
            h_q      <= '0;
        end else begin
            if (core_cnt != 0) core_cnt <= core_cnt - 1;
            if (sha_cs && sha_we) begin
                if (sha_address[7:4] == 4'h1) begin
                    blk[sha_address[3:0]] <= sha_write_data;
                end else if (sha_address == 8'h08) begin
                    if (sha_write_data[0]) h_q <= sha_compress(IV, pack_blk());
                    else if (sha_write_data[1]) h_q <= sha_compress(h_q, pack_blk());
                    core_cnt <= 65;
                end
            end
        end
    end

    // Core read mux, combinational on address
    always_comb begin
        sha_read_data = 32'h0;
        if (sha_address == 8'h09)
            sha_read_data = {31'd0, (core_cnt == 0) && !stub_stall};
        else if (sha_address[7:3] == 5'b00100)
            sha_read_data = h_q[255 - 32*sha_address[2:0] -: 32];
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_abc();
        for (int i = 0; i < 16; i++) words[i] = 32'h0;
        words[0]  = 32'h61626380;
        words[15] = 32'h00000018;
    endtask

    task automatic load_two(input int blkno);
        for (int i = 0; i < 16; i++) words[i] = 32'h0;
        if (blkno == 0) begin
            for (int i = 0; i < 14; i++)
                words[i] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
            words[14] = 32'h80000000;
        end else begin
            words[15] = 32'h000001c0;
        end
    endtask

    // Streams words[] into the DUT; leaves the bench at the CMD-cycle negedge
    task automatic send_block(input logic first, input logic last, input int gap);
        int w = 0;
        int guard = 0;
        bit phase = 1'b0;
        while (w < 16 && guard < 400) begin
            @(negedge clk);
            in_valid = (gap == 0) || phase;
            phase    = ~phase;
            in_data  = words[w];
            in_first = first;
            in_last  = last;
            #1;
            if (in_valid && in_ready) begin
                if (w == 0)  t_w0  = cyc;
                if (w == 15) t_w15 = cyc;
                w++;
            end
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        cmd_seen = {sha_cs, sha_we, sha_address, sha_write_data};
        checks++;
        if (w != 16) begin
            errors++;
            $display("FAIL send_block_timeout: accepted %0d words, required 16", w);
        end
    endtask

    // Drains 8 digest words, optionally stalling one word
    task automatic collect_digest(input int stall_word, input int stall_len);
        int n = 0;
        int guard = 0;
        logic [31:0] hold_val = 32'h0;
        held = 0; hold_bad = 0; t_ov = -1;
        while (n < 8 && guard < 400) begin
            @(negedge clk);
            out_ready = !(n == stall_word && held < stall_len);
            #1;
            if (out_valid && t_ov < 0) t_ov = cyc;
            if (out_valid && n == stall_word && held > 0 && out_data !== hold_val) hold_bad++;
            if (out_valid && !out_ready) begin
                if (held == 0) hold_val = out_data;
                held++;
            end
            if (out_valid && out_ready) begin
                dig[n] = out_data;
                n++;
            end
            guard++;
        end
        out_ready = 1'b1;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL collect_timeout: got %0d words, required 8", n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, busy, err, sha_cs, sha_we, sha_address, sha_write_data, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b busy=%b err=%b cs=%b required all 0",
                     in_ready, out_valid, busy, err, sha_cs);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, out_valid, sha_cs} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: in_ready,busy,out_valid,cs=%b required 1000",
                     {in_ready, busy, out_valid, sha_cs});
        end
    endtask

    task automatic test_single_block();
        load_abc();
        send_block(1'b1, 1'b1, 0);
        checks++;
        if (cmd_seen !== {1'b1, 1'b1, 8'h08, 32'h1}) begin
            errors++;
            $display("FAIL abc_cmd: got %h required %h", cmd_seen, {1'b1, 1'b1, 8'h08, 32'h1});
        end
        checks++;
        if (t_w15 - t_w0 != 15) begin
            errors++;
            $display("FAIL abc_load_span: got %0d required 15", t_w15 - t_w0);
        end
        collect_digest(-1, 0);
        checks++;
        if (t_ov - t_w15 != 68) begin
            errors++;
            $display("FAIL abc_latency: out_valid %0d cycles after word 15, required 68", t_ov - t_w15);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig[i] !== ABC_DIG[i]) begin
                errors++;
                $display("FAIL abc_digest[%0d]: got %h required %h", i, dig[i], ABC_DIG[i]);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL abc_idle_after: in_ready,busy,out_valid=%b required 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_two_block();
        int ov_before;
        int b0_w15;
        ov_before = ov_count;
        load_two(0);
        send_block(1'b1, 1'b0, 0);
        b0_w15 = t_w15;
        checks++;
        if (cmd_seen !== {1'b1, 1'b1, 8'h08, 32'h1}) begin
            errors++;
            $display("FAIL two_cmd0: got %h required INIT", cmd_seen);
        end
        load_two(1);
        send_block(1'b0, 1'b1, 0);
        checks++;
        if (cmd_seen !== {1'b1, 1'b1, 8'h08, 32'h2}) begin
            errors++;
            $display("FAIL two_cmd1: got %h required NEXT", cmd_seen);
        end
        checks++;
        if (t_w0 - b0_w15 != 68) begin
            errors++;
            $display("FAIL two_reload_latency: got %0d required 68", t_w0 - b0_w15);
        end
        checks++;
        if (ov_count != ov_before) begin
            errors++;
            $display("FAIL two_no_early_digest: out_valid seen %0d cycles, required 0", ov_count - ov_before);
        end
        collect_digest(-1, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig[i] !== TWO_DIG[i]) begin
                errors++;
                $display("FAIL two_digest[%0d]: got %h required %h", i, dig[i], TWO_DIG[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        load_abc();
        send_block(1'b1, 1'b1, 1);
        collect_digest(3, 5);
        checks++;
        if (held != 5) begin
            errors++;
            $display("FAIL bp_stall_len: stalled %0d cycles, required 5", held);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL bp_hold: out_data changed %0d times during stall, required 0", hold_bad);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig[i] !== ABC_DIG[i]) begin
                errors++;
                $display("FAIL bp_digest[%0d]: got %h required %h", i, dig[i], ABC_DIG[i]);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int ov_before;
        load_abc();
        send_block(1'b1, 1'b1, 0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, err, sha_cs, sha_we, sha_address, sha_write_data, out_data} !== '0) begin
            errors++;
            $display("FAIL rst_wait_outputs: in_ready=%b out_valid=%b busy=%b cs=%b addr=%h required all 0",
                     in_ready, out_valid, busy, sha_cs, sha_address);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, err, sha_cs, sha_we} !== 6'b100000) begin
            errors++;
            $display("FAIL rst_wait_release: got %b required 100000",
                     {in_ready, out_valid, busy, err, sha_cs, sha_we});
        end
        ov_before = ov_count;
        repeat (100) @(negedge clk);
        checks++;
        if (ov_count != ov_before) begin
            errors++;
            $display("FAIL rst_wait_no_digest: out_valid seen %0d cycles, required 0", ov_count - ov_before);
        end
        send_block(1'b1, 1'b1, 0);
        collect_digest(-1, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dig[i] !== ABC_DIG[i]) begin
                errors++;
                $display("FAIL rst_wait_digest[%0d]: got %h required %h", i, dig[i], ABC_DIG[i]);
            end
        end
    endtask

`ifdef SHA_DRV_WATCHDOG_EN
    task automatic test_watchdog();
        int t_err = -1;
        int guard = 0;
        stub_stall = 1'b1;
        load_abc();
        send_block(1'b1, 1'b1, 0);
        while (t_err < 0 && guard < 300) begin
            @(negedge clk);
            #1;
            if (err) t_err = cyc;
            guard++;
        end
        checks++;
        if (t_err - (t_w15 + 2) != WDOG) begin
            errors++;
            $display("FAIL wdog_timing: err after %0d WAIT cycles, required %0d", t_err - (t_w15 + 2), WDOG);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL wdog_back_to_load: in_ready,busy=%b required 10", {in_ready, busy});
        end
        stub_stall = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL wdog_sticky: err=%b required 1", err);
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear: err=%b required 0", err);
        end
    endtask
`endif

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_single_block();
        test_two_block();
        test_backpressure();
        test_reset_mid_wait();
`ifdef SHA_DRV_WATCHDOG_EN
        test_watchdog();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
